// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates the single memory port between IF fetches and MEM loads/stores.
// Optional ARB_RR_EN macro enables round-robin fairness instead of data-first priority.
module pipeline_mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_read,
  input  logic [31:0]      inst_addr,
  output logic [31:0]      inst_rdata,
  output logic             inst_resp,
  input  logic             data_read,
  input  logic             data_write,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  input  logic [3:0]       data_mbe,
  output logic [31:0]      data_rdata,
  output logic             data_resp,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_mbe,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_resp,
  output logic [CNT_W-1:0] inst_wait_cnt,
  output logic [CNT_W-1:0] data_wait_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a requester holds read/write until its one-cycle resp; mem_* stay stable until mem_resp.
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_mbe_q, mem_mbe_d;
  logic [31:0]        inst_rdata_q, inst_rdata_d;
  logic [31:0]        data_rdata_q, data_rdata_d;
  logic [CNT_W-1:0]   inst_wait_q, inst_wait_d;
  logic [CNT_W-1:0]   data_wait_q, data_wait_d;
  logic               data_pend, grant_i, grant_d;
  logic               unused_addr_lsbs;

  assign unused_addr_lsbs = ^{inst_addr[1:0], data_addr[1:0]};
  assign data_pend        = data_read | data_write;

`ifdef ARB_RR_EN
  // last_grant: 0 = instruction side, 1 = data side
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (data_pend && inst_read) begin
        grant_d = ~last_grant_q;
        grant_i = last_grant_q;
      end else begin
        grant_d = data_pend;
        grant_i = inst_read;
      end
    end
    last_grant_d = last_grant_q;
    if (grant_d) last_grant_d = 1'b1;
    else if (grant_i) last_grant_d = 1'b0;
  end
`else
  always_comb begin
    grant_d = (state_q == IDLE) && data_pend;
    grant_i = (state_q == IDLE) && inst_read && !data_pend;
  end
`endif

  assign inst_resp = (state_q == SERVE_I) && mem_resp && !rst;
  assign data_resp = (state_q == SERVE_D) && mem_resp && !rst;

  always_comb begin
    state_d      = state_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mbe_d    = mem_mbe_q;
    inst_rdata_d = inst_resp ? mem_rdata : inst_rdata_q;
    data_rdata_d = data_resp ? mem_rdata : data_rdata_q;
    if (grant_d) begin
      state_d     = SERVE_D;
      mem_write_d = data_write;
      mem_read_d  = data_read & ~data_write;
      mem_addr_d  = {data_addr[31:2], 2'b00};
      mem_wdata_d = data_wdata;
      mem_mbe_d   = data_mbe;
    end else if (grant_i) begin
      state_d     = SERVE_I;
      mem_read_d  = 1'b1;
      mem_write_d = 1'b0;
      mem_addr_d  = {inst_addr[31:2], 2'b00};
      mem_wdata_d = 32'h0;
      mem_mbe_d   = 4'hF;
    end else if (state_q != IDLE && mem_resp) begin
      state_d     = IDLE;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end

    // A request granted in the same IDLE cycle it is seen has not waited.
    inst_wait_d = inst_wait_q;
    if (inst_read && state_q != SERVE_I && !grant_i && inst_wait_q != {CNT_W{1'b1}})
      inst_wait_d = inst_wait_q + CNT_W'(1);
    data_wait_d = data_wait_q;
    if (data_pend && state_q != SERVE_D && !grant_d && data_wait_q != {CNT_W{1'b1}})
      data_wait_d = data_wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_mbe_q    <= 4'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_wait_q  <= '0;
      data_wait_q  <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mbe_q    <= mem_mbe_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_wait_q  <= inst_wait_d;
      data_wait_q  <= data_wait_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_mbe       = mem_mbe_q;
  assign inst_rdata    = inst_rdata_d;
  assign data_rdata    = data_rdata_d;
  assign inst_wait_cnt = inst_wait_q;
  assign data_wait_cnt = data_wait_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/pipeline_mem_arbiter.md
Name: pipeline_mem_arbiter

Overview:
- Shares one memory port (cache/physical memory side) between the IF-stage instruction fetch and the MEM-stage data access of the RV32I pipeline.
- Latches one request at a time, drives the shared mem_* bus from registers, and routes mem_resp/mem_rdata back to the granted requester only.
- Provides saturating wait-cycle counters for stall analysis.

Parameters:
- CNT_W, 16, width of each wait-cycle counter (saturating).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- inst_read  in  1  IF read request; held until inst_resp.
- inst_addr  in  32  IF byte address.
- inst_rdata  out  32  fetched word.
- inst_resp  out  1  one-cycle completion pulse to IF.
- data_read  in  1  MEM read request; held until data_resp.
- data_write  in  1  MEM write request; held until data_resp.
- data_addr  in  32  MEM byte address.
- data_wdata  in  32  store data.
- data_mbe  in  4  store byte enables.
- data_rdata  out  32  load word.
- data_resp  out  1  one-cycle completion pulse to MEM.
- mem_read  out  1  shared-port read strobe.
- mem_write  out  1  shared-port write strobe.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data.
- mem_mbe  out  4  byte enables.
- mem_rdata  in  32  read data from memory.
- mem_resp  in  1  memory completion, one cycle.
- inst_wait_cnt  out  CNT_W  cycles inst_read was high while not granted.
- data_wait_cnt  out  CNT_W  cycles data_read|data_write was high while not granted.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: IDLE, SERVE_I, SERVE_D. Reset to IDLE.
- Reset values: all mem_* outputs 0, inst_resp and data_resp 0, both wait counters 0.
- IDLE transitions:
  - Data request pending -> SERVE_D. Data has fixed priority, since it is the older instruction.
  - Else inst_read -> SERVE_I.
  - Else stay in IDLE.
- Grant edge: on the transition into SERVE_x, register the request onto the bus. mem_* are valid from the cycle after the request is first seen in IDLE, so issue latency is 1 cycle.
- Address alignment: mem_addr = {addr[31:2],2'b00}.
- Instruction grant: mem_read=1, mem_write=0, mem_mbe=4'hF, mem_wdata=0.
- Data grant: mem_write=data_write, mem_read=data_read & ~data_write. Write wins if both are asserted (illegal input). mem_mbe=data_mbe, mem_wdata=data_wdata.
- In SERVE_x, mem_* are held stable until mem_resp.
- Response cycle (mem_resp=1 in SERVE_x):
  - x_resp=1 combinationally in the same cycle; x_rdata=mem_rdata in the same cycle.
  - Next state is IDLE; mem_read/mem_write are cleared at that edge.
  - Minimum occupancy is 2 cycles per access plus the memory latency.
- Outside the response cycle: inst_rdata and data_rdata hold their last captured value; resp outputs are 0.
- mem_resp in IDLE is ignored; no resp is generated.
- Requester contract: the requester deasserts its request or presents a new one in the cycle after its resp. The arbiter treats any request seen in IDLE as a new request.
- Wait counters: increment by 1 per cycle in which the requester's request is high and the FSM is not in its SERVE state. Saturate at all-ones with no wrap. Cleared only by rst.
- Reset mid-operation: rst in SERVE_x -> IDLE on the next edge, mem_* deasserted, any concurrent mem_resp is dropped, no resp pulse.

Optional Feature:
- ARB_RR_EN defined: round-robin fairness. A 1-bit last_grant register is reset to I.
  - With both requests pending in IDLE, grant the side not equal to last_grant.
  - last_grant updates on each grant.
- ARB_RR_EN undefined: fixed data-over-instruction priority as described; no last_grant register.

Test Plan:
- Reset then idle: hold rst 2 cycles -> all mem_*, resp and counters 0; FSM in IDLE. mem_resp pulsed while idle -> no inst_resp/data_resp.
- Lone fetch: inst_read=1, inst_addr=0x0000_0063, memory answers 3 cycles after mem_read.
  - mem_read=1 from next cycle with mem_addr=0x0000_0060, mbe=F.
  - inst_resp=1 with inst_rdata=0x0130_0093 in the mem_resp cycle.
  - mem_read=0 the following cycle.
- Store: data_write=1, addr=0x8000_0004, wdata=0xDEAD_BEEF, mbe=4'b0011 -> mem_write=1 with those exact values and mem_read=0; data_resp pulses on mem_resp.
- Contention (ARB_RR_EN undefined): inst_read and data_read rise in the same cycle, 2-cycle memory.
  - D is served first; inst_wait_cnt counts through the D service.
  - I is granted after D returns to IDLE.
  - data_wait_cnt stays 0.
- Round-robin (ARB_RR_EN defined): both requesters held continuously for 4 accesses -> grant order D, I, D, I, starting from last_grant=I reset state.
- Reset mid-access: assert rst in SERVE_D coincident with mem_resp -> no data_resp; mem_write=0 next cycle; counters 0.
- Counter saturation: CNT_W=4, I starved by 20 consecutive D accesses -> inst_wait_cnt=4'hF, no wrap.
